// File: rtl/uart_tx_arb_pkg.sv
// Shared types and constants for the round-robin UART transmit arbiter.
package uart_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

    localparam logic [7:0] ID_BASE_DEFAULT = 8'hF0;
    localparam int         IDX_W           = 4;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Combinational round-robin pick: first request at or above the pointer, wrapping.
module rr_select
    import uart_tx_arb_pkg::*;
#(
    parameter int PORTS = 4
) (
    input  logic [PORTS-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [PORTS-1:0] gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [PORTS-1:0]   mask;
    logic [2*PORTS-1:0] dbl;
    logic               found;

    always_comb begin
        mask = '0;
        for (int k = 0; k < PORTS; k++) begin
            mask[k] = (k >= int'(ptr_i));
        end
    end

    // Low half holds requests at/after the pointer, high half the full vector for wrap.
    assign dbl = {req_i, req_i & mask};

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        for (int j = 0; j < 2 * PORTS; j++) begin
            if (dbl[j] && !found) begin
                found = 1'b1;
                idx_o = IDX_W'(j % PORTS);
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        for (int k = 0; k < PORTS; k++) begin
            gnt_o[k] = found && (idx_o == IDX_W'(k));
        end
    end

    assign any_o = found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one uart_tx between several
// AXI-Stream byte requesters, with an optional per-packet port-ID header byte.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int                    PORTS      = 4,
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ID_ENABLE  = 1,
    parameter logic [DATA_WIDTH-1:0] ID_BASE    = DATA_WIDTH'(ID_BASE_DEFAULT)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    input  logic [PORTS-1:0]            s_axis_tlast,
    output logic [PORTS-1:0]            s_axis_tready,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        grant_valid,
    output logic [IDX_W-1:0]            grant_index,
    output logic                        busy
);

    arb_state_t            state_q;
    logic [IDX_W-1:0]      ptr_q;
    logic [IDX_W-1:0]      gidx_q;
    logic [PORTS-1:0]      gnt_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic                  tvalid_q;

    logic [PORTS-1:0]      rr_gnt;
    logic [IDX_W-1:0]      rr_idx;
    logic                  rr_any;

    logic                  out_free;
    logic                  sel_vld;
    logic                  sel_last;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  beat;
    logic [IDX_W-1:0]      ptr_next;

    rr_select #(
        .PORTS(PORTS)
    ) u_rr (
        .req_i(s_axis_tvalid),
        .ptr_i(ptr_q),
        .gnt_o(rr_gnt),
        .idx_o(rr_idx),
        .any_o(rr_any)
    );

    assign out_free      = !tvalid_q || m_axis_tready;
    assign s_axis_tready = (state_q == ST_DATA && out_free) ? gnt_q : '0;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < PORTS; k++) begin
            if (gnt_q[k]) begin
                sel_data = s_axis_tdata[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign sel_vld  = |(s_axis_tvalid & gnt_q);
    assign sel_last = |(s_axis_tlast & gnt_q);
    assign beat     = (state_q == ST_DATA) && out_free && sel_vld;
    assign ptr_next = (gidx_q == IDX_W'(PORTS - 1)) ? '0 : gidx_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            gidx_q   <= '0;
            gnt_q    <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
        end else begin
            // A pending byte leaves whenever the UART accepts; loads below override.
            if (m_axis_tready) begin
                tvalid_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (rr_any) begin
                        gnt_q   <= rr_gnt;
                        gidx_q  <= rr_idx;
                        state_q <= (ID_ENABLE != 0) ? ST_HDR : ST_DATA;
                    end
                end
                ST_HDR: begin
                    if (out_free) begin
                        tdata_q  <= ID_BASE | DATA_WIDTH'(gidx_q);
                        tvalid_q <= 1'b1;
                        state_q  <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (beat) begin
                        tdata_q  <= sel_data;
                        tvalid_q <= 1'b1;
                        if (sel_last) begin
                            ptr_q   <= ptr_next;
                            gnt_q   <= '0;
                            state_q <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign grant_valid   = |gnt_q;
    assign grant_index   = gidx_q;
    assign busy          = (|gnt_q) || tvalid_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: per-cycle vector table plus packet-level sequences.
module tb_uart_tx_arbiter;

    localparam int P = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [P*8-1:0] s_tdata;
    logic [P-1:0]  s_tvalid, s_tlast, s_tready;
    logic [7:0]    m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b1;
    logic          gv;
    logic [3:0]    gi;
    logic          busy;

    uart_tx_arbiter #(.PORTS(P), .DATA_WIDTH(8), .ID_ENABLE(1), .ID_BASE(8'hF0)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast),
        .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .grant_valid(gv), .grant_index(gi), .busy(busy)
    );

    always #5 clk = ~clk;

    // Table-mode direct drive
    logic          tbl_mode = 1'b1;
    logic [P-1:0]  tbl_v = '0, tbl_l = '0;
    logic [P*8-1:0] tbl_d = '0;

    // Packet sources: bytes pushed by the test, consumed on accepted beats
    logic [7:0] mem   [P][8];
    logic       lastf [P][8];
    int         len    [P] = '{default: 0};
    int         base   [P] = '{default: 0};
    int         popped [P] = '{default: 0};
    int         pos    [P];
    logic [P-1:0]   src_v, src_l;
    logic [P*8-1:0] src_d;
    logic [P-1:0]   fire = '0;

    always_comb begin
        src_v = '0;
        src_l = '0;
        src_d = '0;
        for (int p = 0; p < P; p++) begin
            pos[p] = popped[p] - base[p];
            if (pos[p] < len[p]) begin
                src_v[p]         = 1'b1;
                src_l[p]         = lastf[p][pos[p]];
                src_d[p*8 +: 8]  = mem[p][pos[p]];
            end
        end
    end

    assign s_tvalid = tbl_mode ? tbl_v : src_v;
    assign s_tlast  = tbl_mode ? tbl_l : src_l;
    assign s_tdata  = tbl_mode ? tbl_d : src_d;

    always @(negedge clk) fire <= rst ? '0 : (s_tvalid & s_tready);

    always @(posedge clk) begin
        #1;
        for (int p = 0; p < P; p++) begin
            if (fire[p]) popped[p] = popped[p] + 1;
        end
    end

    // Output / grant monitor
    int         cyc = 0;
    logic [7:0] out_q[$];
    int         g_cyc[$];
    logic [3:0] g_idx[$];
    logic       gv_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst && m_tvalid && m_tready) out_q.push_back(m_tdata);
        if (gv && !gv_prev) begin
            g_cyc.push_back(cyc);
            g_idx.push_back(gi);
        end
        gv_prev <= gv;
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_seq(input string name, input int obase);
        int n;
        n = out_q.size() - obase;
        check({name, " count"}, n, exp_q.size());
        for (int i = 0; i < exp_q.size() && i < n; i++)
            check($sformatf("%s byte%0d", name, i), {24'h0, out_q[obase+i]}, {24'h0, exp_q[i]});
    endtask

    task automatic push(input int p, input logic [7:0] d, input logic l);
        mem[p][len[p]]   = d;
        lastf[p][len[p]] = l;
        len[p]           = len[p] + 1;
    endtask

    task automatic clear_srcs();
        for (int p = 0; p < P; p++) begin
            base[p] = popped[p];
            len[p]  = 0;
        end
    endtask

    function automatic logic drained();
        for (int p = 0; p < P; p++)
            if (pos[p] < len[p]) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_idle(input string name, input int budget);
        logic done;
        int   k;
        done = 1'b0;
        k    = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
            done = drained() && !busy;
        end
        check({name, " idle timeout"}, {31'h0, done}, 32'h1);
    endtask

    task automatic wait_pos(input string name, input int p, input int target, input int budget);
        int k;
        k = 0;
        while (pos[p] < target && k < budget) begin
            @(negedge clk);
            k++;
        end
        check({name, " beat timeout"}, {31'h0, pos[p] >= target}, 32'h1);
    endtask

    typedef struct {
        logic       v;
        logic       l;
        logic [7:0] d;
        logic       mr;
        logic       mv;
        logic [7:0] md;
        logic       gv;
        logic [3:0] gi;
        logic [3:0] sr;
        logic       busy;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int ob;
        int gb;

        // Port 2 sends 0x41, 0x42(last); expected per cycle after reset release
        tbl[0] = '{1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 8'h00, 1'b0, 4'd0, 4'b0000, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 8'h41, 1'b1, 1'b0, 8'h00, 1'b1, 4'd2, 4'b0000, 1'b1};
        tbl[2] = '{1'b1, 1'b0, 8'h41, 1'b1, 1'b1, 8'hF2, 1'b1, 4'd2, 4'b0100, 1'b1};
        tbl[3] = '{1'b1, 1'b1, 8'h42, 1'b1, 1'b1, 8'h41, 1'b1, 4'd2, 4'b0100, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h42, 1'b0, 4'd2, 4'b0000, 1'b1};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h42, 1'b0, 4'd2, 4'b0000, 1'b0};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            tbl_v    = {1'b0, tbl[i].v, 2'b00};
            tbl_l    = {1'b0, tbl[i].l, 2'b00};
            tbl_d    = {8'h00, tbl[i].d, 16'h0000};
            m_tready = tbl[i].mr;
            @(negedge clk);
            check($sformatf("vec%0d", i),
                  {13'h0, m_tvalid, m_tdata, gv, gi, s_tready, busy},
                  {13'h0, tbl[i].mv, tbl[i].md, tbl[i].gv, tbl[i].gi, tbl[i].sr, tbl[i].busy});
        end

        // Reset with every port requesting, then four single-byte packets
        @(posedge clk);
        #1;
        rst      = 1'b1;
        tbl_mode = 1'b0;
        clear_srcs();
        for (int p = 0; p < P; p++) push(p, 8'hA0 + 8'(p), 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("reset outputs %0d", i),
                  {15'h0, m_tvalid, m_tdata, gv, gi, s_tready, busy}, 32'h0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        ob = out_q.size();
        gb = g_cyc.size();
        @(posedge clk);
        @(negedge clk);
        check("first grant after reset", {27'h0, gv, gi}, {27'h0, 1'b1, 4'd0});
        wait_idle("all4", 100);
        exp_q = '{8'hF0, 8'hA0, 8'hF1, 8'hA1, 8'hF2, 8'hA2, 8'hF3, 8'hA3};
        check_seq("all4", ob);
        check("all4 grant count", g_cyc.size() - gb, 4);
        for (int i = 0; i < 4 && gb + i < g_idx.size(); i++)
            check($sformatf("all4 grant idx%0d", i), {28'h0, g_idx[gb+i]}, i);
        for (int i = 1; i < 4 && gb + i < g_cyc.size(); i++)
            check($sformatf("all4 grant spacing%0d", i), g_cyc[gb+i] - g_cyc[gb+i-1], 3);

        // Backpressure on the pending header
        @(posedge clk);
        #1;
        rst      = 1'b1;
        m_tready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clear_srcs();
        push(0, 8'h10, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        ob = out_q.size();
        begin
            int k;
            k = 0;
            while (!m_tvalid && k < 10) begin
                @(negedge clk);
                k++;
            end
            check("bp header valid timeout", {31'h0, m_tvalid}, 32'h1);
        end
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check($sformatf("bp hold %0d", i), {23'h0, m_tvalid, m_tdata}, {23'h0, 1'b1, 8'hF0});
            check($sformatf("bp no s_tready %0d", i), {28'h0, s_tready}, 32'h0);
        end
        @(posedge clk);
        #1 m_tready = 1'b1;
        wait_idle("bp", 50);
        exp_q = '{8'hF0, 8'h10};
        check_seq("bp", ob);

        // Port 1 stalls mid-packet while port 3 waits
        @(posedge clk);
        #1;
        clear_srcs();
        push(1, 8'h51, 1'b0);
        push(3, 8'h71, 1'b0);
        push(3, 8'h72, 1'b1);
        ob = out_q.size();
        wait_pos("stall", 1, 1, 20);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("stall hold %0d", i), {26'h0, gv, gi, s_tready[3]},
                  {26'h0, 1'b1, 4'd1, 1'b0});
        end
        @(posedge clk);
        #1 push(1, 8'h52, 1'b1);
        wait_idle("stall", 100);
        exp_q = '{8'hF1, 8'h51, 8'h52, 8'hF3, 8'h71, 8'h72};
        check_seq("stall", ob);

        // Reset while port 0 is in DATA
        @(posedge clk);
        #1;
        clear_srcs();
        push(0, 8'h81, 1'b0);
        push(0, 8'h82, 1'b0);
        push(0, 8'h83, 1'b1);
        wait_pos("midrst", 0, 1, 20);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst outputs", {15'h0, m_tvalid, m_tdata, gv, gi, s_tready, busy}, 32'h0);
        clear_srcs();
        ob = out_q.size();
        @(posedge clk);
        #1;
        push(1, 8'h91, 1'b1);
        push(3, 8'hB3, 1'b1);
        @(posedge clk);
        #1 rst = 1'b0;
        wait_idle("midrst", 100);
        exp_q = '{8'hF1, 8'h91, 8'hF3, 8'hB3};
        check_seq("midrst", ob);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_tx instance between PORTS independent AXI-Stream byte requesters.
- Arbitration is round-robin at packet granularity: once a port wins, it owns the UART until its tlast beat is accepted.
- When ID_ENABLE=1, each packet is preceded by a header byte (ID_BASE | port index), so the far end can demultiplex.
- Sits between the requester FIFOs and the uart_tx s_axis input.

Parameters:
- PORTS, 4, number of requesters (2..16).
- DATA_WIDTH, 8, byte width; must match uart_tx DATA_WIDTH.
- ID_ENABLE, 1, 1 = emit header byte before each packet; 0 = no header.
- ID_BASE, 8'hF0, header byte base; header = ID_BASE | grant index (index occupies the low 4 bits).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- s_axis_tdata  input  PORTS*DATA_WIDTH  requester data; port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
- s_axis_tvalid  input  PORTS  per-port valid
- s_axis_tlast  input  PORTS  per-port end of packet
- s_axis_tready  output  PORTS  per-port ready
- m_axis_tdata  output  DATA_WIDTH  to uart_tx s_axis_tdata
- m_axis_tvalid  output  1  to uart_tx s_axis_tvalid
- m_axis_tready  input  1  from uart_tx s_axis_tready
- grant_valid  output  1  a port currently owns the UART
- grant_index  output  4  index of the owning port
- busy  output  1  grant_valid OR m_axis_tvalid

Behaviour:
- One clock. Reset is synchronous and active-high. During and after reset:
  - s_axis_tready = 0, m_axis_tvalid = 0, m_axis_tdata = 0
  - grant_valid = 0, grant_index = 0, busy = 0
  - round-robin pointer = 0; state = IDLE.
- Output register: a single-entry register drives m_axis_tdata/m_axis_tvalid.
  - The register is "free" when !m_axis_tvalid || m_axis_tready.
  - A transfer occurs on m_axis_tvalid && m_axis_tready.
  - m_axis_tvalid must not drop, and m_axis_tdata must not change, while tvalid=1 and tready=0.
- States:
  - IDLE:
    - If any s_axis_tvalid is set, select the first set bit searching upward from the pointer, wrapping at PORTS-1 to 0.
    - Register grant_index, set grant_valid = 1.
    - Next state is HDR if ID_ENABLE, else DATA.
    - s_axis_tready = 0 in IDLE.
  - HDR:
    - When the output register is free, load ID_BASE | grant_index with tvalid = 1, then go to DATA.
    - s_axis_tready = 0 in HDR.
  - DATA:
    - s_axis_tready[grant_index] = output register free; all other bits are 0.
    - On s_axis_tvalid && s_axis_tready for the granted port, load its byte into the output register.
    - If that beat has tlast = 1: pointer <= (grant_index+1) mod PORTS, grant_valid <= 0, state <= IDLE.
- Latency:
  - Request at cycle t with the arbiter idle → grant_valid at t+1 → header m_axis_tvalid at t+2 → first payload byte accepted no earlier than t+2.
  - With ID_ENABLE=0, the first payload byte is accepted at t+1.
- Back-to-back packets: there is always exactly one IDLE cycle between a tlast acceptance and the next grant. A new grant may be issued while the previous last byte is still held in the output register.
- A granted port that deasserts tvalid mid-packet keeps the grant indefinitely. There is no timeout and no preemption.
- Single-beat packet (tlast on the first beat) is legal: with ID_ENABLE=1 it is sent as header + 1 byte.
- tvalid from non-granted ports is ignored and their tready stays 0. Their data is not consumed.
- Requests that arrive in the same cycle as the tlast acceptance are considered in the following IDLE cycle, using the updated pointer.
- Reset mid-packet:
  - Any byte in the output register is discarded.
  - Grant, pointer and state return to their reset values.
  - The partial packet is not resumed.

Decomposition:
- Package uart_tx_arb_pkg holds:
  - state encoding (IDLE, HDR, DATA)
  - default ID_BASE
  - the 4-bit width constant for grant_index.
- Sub-module rr_select is purely combinational: request vector + pointer → one-hot grant + index, using a mask/double-width priority encode. Instantiate it once.

Test Plan:
- Reset: hold rst 3 cycles with all tvalid = 1 → all outputs 0 throughout; the first grant after release goes to port 0.
- Single port, ID_ENABLE=1: port 2 sends bytes 0x41, 0x42 (tlast on 0x42), m_axis_tready always 1 → m_axis carries 0xF2, 0x41, 0x42 in order. grant_valid falls the cycle after 0x42 is accepted.
- All four ports request 1-byte packets simultaneously → headers in order 0xF0, 0xF1, 0xF2, 0xF3, each followed by its data byte, with exactly one IDLE cycle between packets.
- Backpressure: hold m_axis_tready = 0 for 20 cycles with the header pending → m_axis_tdata stays 0xF0 and tvalid stays 1. No s_axis_tready is asserted until the header transfers.
- Mid-packet stall: port 1 drops tvalid for 10 cycles after its first byte while port 3 requests → grant_index stays 1. Port 3 is served only after port 1's tlast.
- Reset during DATA of port 0 → m_axis_tvalid = 0 the next cycle, pointer = 0. A fresh request from port 1 gets header 0xF1.
